mem_stage: RTL
==============

Name: mem_stage

Overview:
- Memory-access pipeline stage directly downstream of the execute stage.
- Consumes the execute stage's ALU result as the effective address (or as the pass-through result), plus register Rt as store data.
- Performs aligned byte/half/word loads and stores over a req/ready data-memory handshake, stalling upstream until the access completes.
- Presents a registered, sign/zero-extended result to the write-back stage.

Parameters:
- TIMEOUT_CYCLES, 16, max cycles in WAIT without dmemReady before a bus error is flagged (>=1).
- ADDR_WIDTH, 32, data-memory address width; must be 32 in this core.

Ports:
- clock  input  1  single clock for the stage.
- reset  input  1  synchronous, active-high reset.
- inValid  input  1  execute stage holds a valid instruction.
- aluOutput  input  32  ALU result: effective address or pass-through value.
- storeData  input  32  register Rt value for stores.
- memRead  input  1  instruction is a load.
- memWrite  input  1  instruction is a store.
- memSize  input  2  00 byte, 01 half, 10 word, 11 treated as word.
- loadUnsigned  input  1  1 = zero-extend loads, 0 = sign-extend.
- stall  output  1  upstream must hold its inputs this cycle.
- resultValid  output  1  memResult valid (one-cycle pulse).
- memResult  output  32  load data or pass-through ALU result.
- addressError  output  1  one-cycle pulse: misaligned access dropped.
- busError  output  1  one-cycle pulse: handshake timed out.
- dmemRequest  output  1  memory request, held until dmemReady.
- dmemWriteEnable  output  1  request is a store.
- dmemAddress  output  32  word-aligned address ({addr[31:2],2'b00}).
- dmemByteEnable  output  4  active byte lanes.
- dmemWriteData  output  32  store data replicated into lanes.
- dmemReadData  input  32  read word, valid when dmemReady.
- dmemReady  input  1  memory completes the access this cycle.

Behaviour:
- Reset: synchronous. State IDLE. All outputs 0, timeout counter 0. Applies mid-WAIT: dmemRequest is 0 from the following cycle; no result or error pulse is produced.
- memOp = memRead | memWrite. If both are set, the access is a store.
- Alignment:
  - half requires addr[0]=0.
  - word/reserved requires addr[1:0]=00.
  - byte is always aligned.
- IDLE:
  - inValid & !memOp: next cycle resultValid=1, memResult=aluOutput. stall=0. Latency 1.
  - inValid & memOp & misaligned: next cycle addressError=1, resultValid=0. No request issued. stall=0. Stay IDLE.
  - inValid & memOp & aligned: stall=1 combinationally. Latch address, size, unsigned flag, store flag, lane-formatted data. Next state WAIT. Counter cleared.
- WAIT:
  - stall=1. dmemRequest=1 with all dmem outputs stable.
  - dmemReady=1: latch extended read data (or aluOutput for stores) into memResult. Next state DONE.
  - Otherwise counter increments. When it reaches TIMEOUT_CYCLES-1 without ready: next state DONE with error flag set.
  - dmemRequest drops in the cycle after ready or timeout.
- DONE (one cycle):
  - stall=0.
  - Success: resultValid=1. Timeout: busError=1 and resultValid=0.
  - Next state IDLE. Upstream advances at the end of this cycle, so a new instruction is evaluated in IDLE on the following cycle.
  - Throughput: a zero-wait-state memory op takes 3 cycles.
- Byte enables:
  - byte: 4'b0001<<addr[1:0].
  - half: 4'b0011<<{addr[1],1'b0}.
  - word: 4'b1111.
- Store data:
  - byte: {4{d[7:0]}}.
  - half: {2{d[15:0]}}.
  - word: d.
- Load extract:
  - byte from lane addr[1:0].
  - half from lane pair addr[1].
  - Extend to 32 bits per loadUnsigned.
- dmemReady is ignored outside WAIT.
- inValid=0 in IDLE: no pulses, stall=0.

Decomposition:
- Shared package mem_stage_pkg:
  - memSize encoding constants.
  - State enum IDLE/WAIT/DONE.
  - TIMEOUT_CYCLES default.
- Sub-module load_store_align (combinational). Inputs: address low bits, memSize, loadUnsigned, storeData, raw read word. Outputs: byteEnable, lane-replicated write data, extended load value, misaligned flag.
- The FSM and registers stay in mem_stage.

Test Plan:
- Pass-through: inValid, memRead=memWrite=0, aluOutput=0x12345678 -> next cycle resultValid=1, memResult=0x12345678, stall never 1.
- Signed byte load:
  - Stimulus: addr 0x1003, memSize=00, loadUnsigned=0, memory returns 0x80FFFFFF after 2 wait cycles.
  - Required: dmemAddress=0x1000, byteEnable=1000, memResult=0xFFFFFF80, resultValid only in DONE.
  - Repeat with loadUnsigned=1 -> 0x00000080.
- Half store:
  - Stimulus: addr 0x2002, storeData=0xAAAABEEF, zero-wait memory.
  - Required: dmemWriteEnable=1, byteEnable=1100, dmemWriteData=0xBEEFBEEF, stall high for exactly 2 cycles.
- Misaligned word load at 0x3001 -> addressError pulse 1 cycle, dmemRequest never asserted, stall=0.
- Timeout with TIMEOUT_CYCLES=4 and dmemReady held 0 -> request high 4 cycles, then busError pulse, resultValid=0, return to IDLE.
- Reset asserted in 2nd WAIT cycle -> next cycle dmemRequest=0, stall=0, no resultValid/busError. The following op completes normally.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory-access stage: access-size encoding,
// FSM state encoding and the default handshake timeout.
package mem_stage_pkg;

    // memSize encoding; the reserved code behaves as a word access
    localparam logic [1:0] MEM_SIZE_BYTE = 2'b00;
    localparam logic [1:0] MEM_SIZE_HALF = 2'b01;
    localparam logic [1:0] MEM_SIZE_WORD = 2'b10;
    localparam logic [1:0] MEM_SIZE_RSVD = 2'b11;

    localparam int TIMEOUT_CYCLES_DEFAULT = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/mem_stage_load_store_align.sv
// Lane steering for aligned sub-word accesses: byte enables, store data
// replication, load lane extraction with sign/zero extension, and the
// misalignment check.
module load_store_align
    import mem_stage_pkg::*;
(
    input  logic [1:0]  addr_lo_i,
    input  logic [1:0]  mem_size_i,
    input  logic        load_unsigned_i,
    input  logic [31:0] store_data_i,
    input  logic [31:0] read_word_i,
    output logic [3:0]  byte_enable_o,
    output logic [31:0] write_data_o,
    output logic [31:0] load_value_o,
    output logic        misaligned_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Pick the addressed byte and half-word out of the read word
    always_comb begin
        byte_sel = read_word_i[7:0];
        case (addr_lo_i)
            2'd0:    byte_sel = read_word_i[7:0];
            2'd1:    byte_sel = read_word_i[15:8];
            2'd2:    byte_sel = read_word_i[23:16];
            default: byte_sel = read_word_i[31:24];
        endcase
        half_sel = addr_lo_i[1] ? read_word_i[31:16] : read_word_i[15:0];
    end

    // Size-dependent enables, replicated store data and extended load value
    always_comb begin
        byte_enable_o = 4'b1111;
        write_data_o  = store_data_i;
        load_value_o  = read_word_i;
        misaligned_o  = 1'b0;
        case (mem_size_i)
            MEM_SIZE_BYTE: begin
                byte_enable_o = 4'b0001 << addr_lo_i;
                write_data_o  = {4{store_data_i[7:0]}};
                load_value_o  = {{24{~load_unsigned_i & byte_sel[7]}}, byte_sel};
            end
            MEM_SIZE_HALF: begin
                byte_enable_o = addr_lo_i[1] ? 4'b1100 : 4'b0011;
                write_data_o  = {2{store_data_i[15:0]}};
                load_value_o  = {{16{~load_unsigned_i & half_sel[15]}}, half_sel};
                misaligned_o  = addr_lo_i[0];
            end
            default: begin
                misaligned_o  = |addr_lo_i;
            end
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage. Pass-through results retire in one cycle;
// loads/stores go through a req/ready handshake with a bounded wait and
// retire from DONE with a registered, extended result.
//
//   state   | meaning
//   --------+---------------------------------------------------------
//   ST_IDLE | accepting; pass-through and misaligned ops retire here
//   ST_WAIT | dmemRequest held, waiting for dmemReady or timeout
//   ST_DONE | one-cycle retire: resultValid or busError pulse
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT,
    parameter int ADDR_WIDTH     = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  inValid,
    input  logic [ADDR_WIDTH-1:0] aluOutput,
    input  logic [31:0]           storeData,
    input  logic                  memRead,
    input  logic                  memWrite,
    input  logic [1:0]            memSize,
    input  logic                  loadUnsigned,
    output logic                  stall,
    output logic                  resultValid,
    output logic [31:0]           memResult,
    output logic                  addressError,
    output logic                  busError,
    output logic                  dmemRequest,
    output logic                  dmemWriteEnable,
    output logic [ADDR_WIDTH-1:0] dmemAddress,
    output logic [3:0]            dmemByteEnable,
    output logic [31:0]           dmemWriteData,
    input  logic [31:0]           dmemReadData,
    input  logic                  dmemReady
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(TIMEOUT_CYCLES - 1);

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [1:0]              size_q, size_d;
    logic                    unsigned_q, unsigned_d;
    logic                    store_q, store_d;
    logic [3:0]              be_q, be_d;
    logic [31:0]             wdata_q, wdata_d;
    logic                    req_q, req_d;
    logic [31:0]             result_q, result_d;
    logic                    rvalid_q, rvalid_d;
    logic                    aerr_q, aerr_d;
    logic                    berr_q, berr_d;

    logic                    mem_op;
    logic                    use_live;
    logic [1:0]              al_addr_lo;
    logic [1:0]              al_size;
    logic                    al_unsigned;
    logic [3:0]              al_be;
    logic [31:0]             al_wdata;
    logic [31:0]             al_load;
    logic                    al_misaligned;

    assign mem_op   = memRead | memWrite;

    // In IDLE the aligner formats the incoming op; afterwards it decodes the
    // read word against the latched access so upstream changes are harmless.
    assign use_live    = (state_q == ST_IDLE);
    assign al_addr_lo  = use_live ? aluOutput[1:0] : addr_q[1:0];
    assign al_size     = use_live ? memSize        : size_q;
    assign al_unsigned = use_live ? loadUnsigned   : unsigned_q;

    load_store_align u_align (
        .addr_lo_i       (al_addr_lo),
        .mem_size_i      (al_size),
        .load_unsigned_i (al_unsigned),
        .store_data_i    (storeData),
        .read_word_i     (dmemReadData),
        .byte_enable_o   (al_be),
        .write_data_o    (al_wdata),
        .load_value_o    (al_load),
        .misaligned_o    (al_misaligned)
    );

    // Next-state, latch and pulse logic for the access FSM
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        size_d     = size_q;
        unsigned_d = unsigned_q;
        store_d    = store_q;
        be_d       = be_q;
        wdata_d    = wdata_q;
        req_d      = req_q;
        result_d   = result_q;
        rvalid_d   = 1'b0;
        aerr_d     = 1'b0;
        berr_d     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (inValid) begin
                    if (!mem_op) begin
                        rvalid_d = 1'b1;
                        result_d = aluOutput;
                    end else if (al_misaligned) begin
                        aerr_d = 1'b1;
                    end else begin
                        addr_d     = aluOutput;
                        size_d     = memSize;
                        unsigned_d = loadUnsigned;
                        store_d    = memWrite;
                        be_d       = al_be;
                        wdata_d    = al_wdata;
                        req_d      = 1'b1;
                        cnt_d      = '0;
                        state_d    = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (dmemReady) begin
                    result_d = store_q ? addr_q : al_load;
                    rvalid_d = 1'b1;
                    req_d    = 1'b0;
                    state_d  = ST_DONE;
                end else if (cnt_q == CNT_TERM) begin
                    berr_d  = 1'b1;
                    req_d   = 1'b0;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                req_d   = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            addr_q     <= '0;
            size_q     <= '0;
            unsigned_q <= 1'b0;
            store_q    <= 1'b0;
            be_q       <= '0;
            wdata_q    <= '0;
            req_q      <= 1'b0;
            result_q   <= '0;
            rvalid_q   <= 1'b0;
            aerr_q     <= 1'b0;
            berr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            size_q     <= size_d;
            unsigned_q <= unsigned_d;
            store_q    <= store_d;
            be_q       <= be_d;
            wdata_q    <= wdata_d;
            req_q      <= req_d;
            result_q   <= result_d;
            rvalid_q   <= rvalid_d;
            aerr_q     <= aerr_d;
            berr_q     <= berr_d;
        end
    end

    // Stall covers the accepting IDLE cycle and every WAIT cycle; it is
    // forced low while reset is applied.
    assign stall = ~reset &
                   (((state_q == ST_IDLE) & inValid & mem_op & ~al_misaligned) |
                    (state_q == ST_WAIT));

    assign resultValid     = rvalid_q;
    assign memResult       = result_q;
    assign addressError    = aerr_q;
    assign busError        = berr_q;
    assign dmemRequest     = req_q;
    assign dmemWriteEnable = store_q;
    assign dmemAddress     = {addr_q[ADDR_WIDTH-1:2], 2'b00};
    assign dmemByteEnable  = be_q;
    assign dmemWriteData   = wdata_q;

endmodule
